// File: rtl/bsg_aes_pkg.sv
// Shared AES tables, mode encoding and helper functions for the multimode encryptor.
package bsg_aes_pkg;

  typedef enum logic [1:0] {
    MODE_128 = 2'd0,
    MODE_192 = 2'd1,
    MODE_256 = 2'd2,
    MODE_BAD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [7:0] sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] rcon [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [3:0] nk_f(input mode_e mode);
    case (mode)
      MODE_128: return 4'd4;
      MODE_192: return 4'd6;
      MODE_256: return 4'd8;
      default:  return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_f(input mode_e mode);
    case (mode)
      MODE_128: return 4'd10;
      MODE_192: return 4'd12;
      MODE_256: return 4'd14;
      default:  return 4'd10;
    endcase
  endfunction

  // Words generated after the key itself: 4*(Nr+1) - Nk.
  function automatic logic [5:0] exp_cycles_f(input mode_e mode);
    case (mode)
      MODE_128: return 6'd40;
      MODE_192: return 6'd46;
      MODE_256: return 6'd52;
      default:  return 6'd40;
    endcase
  endfunction

  function automatic logic [7:0] xtime_f(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col_f(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime_f(a0) ^ xtime_f(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime_f(a1) ^ xtime_f(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime_f(a2) ^ xtime_f(a3) ^ a3,
            xtime_f(a0) ^ a0 ^ a1 ^ a2 ^ xtime_f(a3)};
  endfunction

  function automatic logic [31:0] sub_word_f(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

endpackage

// File: rtl/bsg_aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when final_i), AddRoundKey.
module bsg_aes_round
  import bsg_aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  logic         final_i,
  output logic [127:0] state_o
);

  logic [7:0]   sb_s [16];
  logic [7:0]   sr_s [16];
  logic [127:0] mix_s;

  // Byte k of the block is column k/4, row k%4; row r rotates left by r columns.
  always_comb begin
    sb_s  = '{default: 8'h00};
    sr_s  = '{default: 8'h00};
    mix_s = 128'h0;
    for (int k = 0; k < 16; k++) begin
      sb_s[k] = sbox[state_i[127-8*k -: 8]];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[4*c+r] = sb_s[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (final_i) begin
        mix_s[127-32*c -: 32] = {sr_s[4*c], sr_s[4*c+1], sr_s[4*c+2], sr_s[4*c+3]};
      end else begin
        mix_s[127-32*c -: 32] = mix_col_f({sr_s[4*c], sr_s[4*c+1], sr_s[4*c+2], sr_s[4*c+3]});
      end
    end
    state_o = mix_s ^ key_i;
  end

endmodule

// File: rtl/bsg_aes_encrypt_multimode.sv
// Multicycle AES-128/192/256 encryptor: explicit key expansion, then unroll_p rounds per cycle.
// Optional round-key reuse across transactions is enabled by defining BSG_AES_KEY_CACHE_EN.
module bsg_aes_encrypt_multimode #(
  parameter int max_key_width_p = 256,
  parameter int unroll_p        = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic [127:0]               data_i,
  input  logic [max_key_width_p-1:0] key_i,
  input  logic [1:0]                 mode_i,
  output logic                       v_o,
  output logic [127:0]               data_o,
  output logic                       err_o,
  input  logic                       yumi_i
);
  import bsg_aes_pkg::*;

  state_e       state_r;
  mode_e        mode_r;
  logic [127:0] blk_r;
  logic [5:0]   wi_r;
  logic [3:0]   j_r;
  logic [3:0]   rc_r;
  logic [3:0]   rnd_r;
  logic [31:0]  rk_r [60];

  logic         accept_s, mode_bad_s, hit_s, load_s;
  logic [255:0] key_pad_s, key_mask_s, key_m_s;
  logic [5:0]   nk_s, last_wi_s;
  logic [3:0]   nr_s;
  logic [31:0]  prev_w_s, back_w_s, temp_w_s, new_w_s;
  logic [127:0] chain_s [unroll_p+1];

  assign accept_s  = v_i & ready_o;
  assign load_s    = accept_s & ~mode_bad_s & ~hit_s;
  assign nk_s      = 6'(nk_f(mode_r));
  assign nr_s      = nr_f(mode_r);
  assign last_wi_s = nk_s + exp_cycles_f(mode_r) - 6'd1;

  // Left-align the key into 256 bits and zero the bits the selected mode ignores.
  always_comb begin
    key_pad_s = 256'h0;
    key_pad_s[255 -: max_key_width_p] = key_i;
    case (mode_i)
      2'd0:    key_mask_s = {{128{1'b1}}, {128{1'b0}}};
      2'd1:    key_mask_s = {{192{1'b1}}, {64{1'b0}}};
      default: key_mask_s = {256{1'b1}};
    endcase
    key_m_s = key_pad_s & key_mask_s;
  end

  // Illegal: reserved encoding, or a key wider than this instance supports.
  always_comb begin
    if (mode_i == 2'd3) begin
      mode_bad_s = 1'b1;
    end else begin
      mode_bad_s = (32 * int'(nk_f(mode_e'(mode_i)))) > max_key_width_p;
    end
  end

`ifdef BSG_AES_KEY_CACHE_EN
  logic         tag_v_r;
  mode_e        tag_mode_r;
  logic [255:0] tag_key_r;

  assign hit_s = tag_v_r && (tag_mode_r == mode_e'(mode_i)) && (tag_key_r == key_m_s);

  // Tag follows the store: cleared while it is rewritten, set once expansion completes.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tag_v_r    <= 1'b0;
      tag_mode_r <= MODE_128;
      tag_key_r  <= 256'h0;
    end else if (accept_s && mode_bad_s) begin
      tag_v_r <= 1'b0;
    end else if (load_s) begin
      tag_v_r    <= 1'b0;
      tag_mode_r <= mode_e'(mode_i);
      tag_key_r  <= key_m_s;
    end else if ((state_r == ST_EXPAND) && (wi_r == last_wi_s)) begin
      tag_v_r <= 1'b1;
    end
  end
`else
  assign hit_s = 1'b0;
`endif

  // Next schedule word: j_r tracks i mod Nk, rc_r tracks i/Nk - 1.
  always_comb begin
    prev_w_s = rk_r[wi_r - 6'd1];
    back_w_s = rk_r[wi_r - nk_s];
    if (j_r == 4'd0) begin
      temp_w_s = sub_word_f({prev_w_s[23:0], prev_w_s[31:24]}) ^ {rcon[rc_r], 24'h000000};
    end else if ((mode_r == MODE_256) && (j_r == 4'd4)) begin
      temp_w_s = sub_word_f(prev_w_s);
    end else begin
      temp_w_s = prev_w_s;
    end
    new_w_s = back_w_s ^ temp_w_s;
  end

  // Round-key store: key words at accept, one expanded word per EXPAND cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < 60; k++) rk_r[k] <= 32'h0;
    end else if (load_s) begin
      for (int k = 0; k < 8; k++) rk_r[k] <= key_m_s[255-32*k -: 32];
    end else if (state_r == ST_EXPAND) begin
      rk_r[wi_r] <= new_w_s;
    end
  end

  assign chain_s[0] = (rnd_r == 4'd0) ? (blk_r ^ {rk_r[0], rk_r[1], rk_r[2], rk_r[3]}) : blk_r;

  for (genvar u = 0; u < unroll_p; u++) begin : g_round
    logic [3:0]   rn_s;
    logic [5:0]   base_s;
    logic [127:0] rkey_s;

    assign rn_s   = rnd_r + 4'(u + 1);
    assign base_s = {rn_s, 2'b00};
    assign rkey_s = {rk_r[base_s], rk_r[base_s + 6'd1], rk_r[base_s + 6'd2], rk_r[base_s + 6'd3]};

    bsg_aes_round u_round (
      .state_i (chain_s[u]),
      .key_i   (rkey_s),
      .final_i (rn_s == nr_s),
      .state_o (chain_s[u+1])
    );
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= ST_IDLE;
      mode_r  <= MODE_128;
      blk_r   <= 128'h0;
      wi_r    <= 6'd0;
      j_r     <= 4'd0;
      rc_r    <= 4'd0;
      rnd_r   <= 4'd0;
      ready_o <= 1'b1;
      v_o     <= 1'b0;
      data_o  <= 128'h0;
      err_o   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            mode_r  <= mode_e'(mode_i);
            blk_r   <= data_i;
            wi_r    <= 6'(nk_f(mode_e'(mode_i)));
            j_r     <= 4'd0;
            rc_r    <= 4'd0;
            rnd_r   <= 4'd0;
            ready_o <= 1'b0;
            if (mode_bad_s) begin
              state_r <= ST_DONE;
              v_o     <= 1'b1;
              err_o   <= 1'b1;
              data_o  <= 128'h0;
            end else if (hit_s) begin
              state_r <= ST_ROUND;
            end else begin
              state_r <= ST_EXPAND;
            end
          end
        end
        ST_EXPAND: begin
          wi_r <= wi_r + 6'd1;
          j_r  <= (j_r == (nk_s[3:0] - 4'd1)) ? 4'd0 : (j_r + 4'd1);
          if (j_r == 4'd0) rc_r <= rc_r + 4'd1;
          if (wi_r == last_wi_s) state_r <= ST_ROUND;
        end
        ST_ROUND: begin
          blk_r <= chain_s[unroll_p];
          rnd_r <= rnd_r + 4'(unroll_p);
          if ((rnd_r + 4'(unroll_p)) == nr_s) begin
            state_r <= ST_DONE;
            v_o     <= 1'b1;
            err_o   <= 1'b0;
            data_o  <= chain_s[unroll_p];
          end
        end
        ST_DONE: begin
          if (yumi_i) begin
            state_r <= ST_IDLE;
            v_o     <= 1'b0;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          v_o     <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_aes_encrypt_multimode.sv
// Directed FIPS-197 vectors, illegal mode, mid-flight reset and (with BSG_AES_KEY_CACHE_EN) key reuse.
module tb_bsg_aes_encrypt_multimode;

  logic         clk_i = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         v_i = 1'b0;
  logic         ready_o;
  logic [127:0] data_i = 128'h0;
  logic [255:0] key_i = 256'h0;
  logic [1:0]   mode_i = 2'd0;
  logic         v_o;
  logic [127:0] data_o;
  logic         err_o;
  logic         yumi_i = 1'b0;

  int total_cnt = 0;
  int bad_cnt   = 0;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

`ifdef BSG_AES_KEY_CACHE_EN
  localparam int HIT_LAT = 10;
`else
  localparam int HIT_LAT = 50;
`endif

  bsg_aes_encrypt_multimode dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .key_i     (key_i),
    .mode_i    (mode_i),
    .v_o       (v_o),
    .data_o    (data_o),
    .err_o     (err_o),
    .yumi_i    (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // lat counts rising edges after the accept edge until v_o is seen high.
  task automatic run_block(input string tag, input logic [1:0] mode, input logic [255:0] key,
                           input logic [127:0] pt, input logic [127:0] ct, input int exp_lat,
                           input logic exp_err, input int hold);
    int lat;
    @(negedge clk_i);
    check_eq({tag, "_ready"}, 128'(ready_o), 128'd1);
    v_i = 1'b1; mode_i = mode; key_i = key; data_i = pt;
    @(posedge clk_i); #1;
    v_i = 1'b0; mode_i = ~mode; key_i = ~key; data_i = ~pt;
    lat = 0;
    if (exp_lat > 1) begin
      yumi_i = 1'b1;
      @(posedge clk_i); #1;
      yumi_i = 1'b0;
      lat = 1;
    end
    while (!v_o && lat < 300) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    check_eq({tag, "_data"}, data_o, ct);
    check_eq({tag, "_err"}, 128'(err_o), 128'(exp_err));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk_i); #1;
      check_eq({tag, "_hold_v"}, 128'(v_o), 128'd1);
      check_eq({tag, "_hold_data"}, data_o, ct);
      check_eq({tag, "_hold_err"}, 128'(err_o), 128'(exp_err));
    end
    yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
    check_eq({tag, "_ready_after"}, 128'(ready_o), 128'd1);
    check_eq({tag, "_v_after"}, 128'(v_o), 128'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("rst_ready", 128'(ready_o), 128'd1);
    check_eq("rst_v", 128'(v_o), 128'd0);
    check_eq("rst_data", data_o, 128'h0);
    check_eq("rst_err", 128'(err_o), 128'd0);

    run_block("t1_aes128", 2'd0, K128, PT, CT128, 50, 1'b0, 0);
    run_block("t2_aes192", 2'd1, K192, PT, CT192, 58, 1'b0, 0);
    run_block("t3_aes256", 2'd2, K256, PT, CT256, 66, 1'b0, 0);
    // Illegal mode: result is visible in the first cycle after the accept edge.
    run_block("t4_illegal", 2'd3, K128, PT, 128'h0, 0, 1'b1, 5);

    // Reset 20 cycles into an AES-128 block, then rerun it.
    @(negedge clk_i);
    v_i = 1'b1; mode_i = 2'd0; key_i = K128; data_i = PT;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;
    check_eq("t5_busy_ready", 128'(ready_o), 128'd0);
    reset_n_i = 1'b0;
    #1;
    check_eq("t5_rst_v", 128'(v_o), 128'd0);
    check_eq("t5_rst_ready", 128'(ready_o), 128'd1);
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("t5_release_v", 128'(v_o), 128'd0);
    run_block("t5_rerun", 2'd0, K128, PT, CT128, 50, 1'b0, 0);

    // Illegal mode drops any cached schedule, so the first AES-128 expands again.
    run_block("t6_flush", 2'd3, K256, PT, 128'h0, 0, 1'b1, 0);
    run_block("t6_first", 2'd0, K128, PT, CT128, 50, 1'b0, 0);
    run_block("t6_second", 2'd0, K128, PT, CT128, HIT_LAT, 1'b0, 0);
    run_block("t6_aes192", 2'd1, K192, PT, CT192, 58, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
